// File: rtl/sop_eval_seq.sv
// rtl/sop_eval_seq.sv - sequential sum-of-products evaluator; option macro SOP_EVAL_HIT_COUNT_EN
module sop_eval_seq #(
  parameter int  NIN   = 6,
  parameter int  NTERM = 16,
  localparam int IW    = $clog2(NTERM)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_cfg_we,
  input  logic [IW-1:0] i_cfg_idx,
  input  logic [NIN-1:0] i_cfg_care,
  input  logic [NIN-1:0] i_cfg_val,
  input  logic          i_cfg_en,
  output logic          o_busy,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [NIN-1:0] i_in_vec,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic          o_out_f,
  output logic [IW-1:0] o_out_hit_idx,
  output logic [IW:0]   o_out_hit_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [NIN-1:0]  r_care [NTERM];
  logic [NIN-1:0]  r_val  [NTERM];
  logic [NTERM-1:0] r_en;
  logic [NIN-1:0]  r_vec, w_vec_nxt;
  logic [IW-1:0]   r_idx, w_idx_nxt;
  logic            r_f, w_f_nxt;
  logic [IW-1:0]   r_hit_idx, w_hit_idx_nxt;
  logic [IW:0]     r_hit_cnt, w_hit_cnt_nxt;
  logic            r_out_valid, r_busy, r_in_ready;
  logic [NTERM-1:0] w_match;
  logic            w_hit, w_last, w_cfg_ok;

  // The table may only change while no evaluation is in flight
  assign w_cfg_ok = (r_state == S_IDLE) && i_cfg_we;
  assign w_hit    = w_match[r_idx];
  assign w_last   = (r_idx == IW'(NTERM - 1));

  // Per-slot cube match against the latched input vector
  always_comb begin
    w_match = '0;
    for (int t = 0; t < NTERM; t++)
      w_match[t] = r_en[t] & (((r_vec ^ r_val[t]) & r_care[t]) == '0);
  end

  // Next-state and next datapath values
  always_comb begin
    w_state_nxt   = r_state;
    w_vec_nxt     = r_vec;
    w_idx_nxt     = r_idx;
    w_f_nxt       = r_f;
    w_hit_idx_nxt = r_hit_idx;
    w_hit_cnt_nxt = r_hit_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_in_valid) begin
          w_vec_nxt     = i_in_vec;
          w_idx_nxt     = '0;
          w_f_nxt       = 1'b0;
          w_hit_idx_nxt = '0;
          w_hit_cnt_nxt = '0;
          w_state_nxt   = S_SCAN;
        end
      end
      S_SCAN: begin
`ifdef SOP_EVAL_HIT_COUNT_EN
        // Full scan: count every match, remember only the first
        if (w_hit) begin
          w_hit_cnt_nxt = r_hit_cnt + (IW+1)'(1);
          w_f_nxt       = 1'b1;
          if (r_hit_cnt == '0) w_hit_idx_nxt = r_idx;
        end
        if (w_last) w_state_nxt = S_DONE;
        else        w_idx_nxt   = r_idx + IW'(1);
`else
        // Early exit on the first matching cube; count stays zero
        if (w_hit) begin
          w_f_nxt       = 1'b1;
          w_hit_idx_nxt = r_idx;
          w_state_nxt   = S_DONE;
        end else if (w_last) begin
          w_state_nxt   = S_DONE;
        end else begin
          w_idx_nxt     = r_idx + IW'(1);
        end
`endif
      end
      S_DONE: begin
        if (i_out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, datapath, enables and registered handshake outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_vec       <= '0;
      r_idx       <= '0;
      r_f         <= 1'b0;
      r_hit_idx   <= '0;
      r_hit_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_en        <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_vec       <= w_vec_nxt;
      r_idx       <= w_idx_nxt;
      r_f         <= w_f_nxt;
      r_hit_idx   <= w_hit_idx_nxt;
      r_hit_cnt   <= w_hit_cnt_nxt;
      r_out_valid <= (w_state_nxt == S_DONE);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_in_ready  <= (w_state_nxt == S_IDLE);
      for (int t = 0; t < NTERM; t++)
        if (w_cfg_ok && (i_cfg_idx == IW'(t))) r_en[t] <= i_cfg_en;
    end
  end

  // Cube storage; contents are don't-care until the slot is enabled
  always_ff @(posedge i_clk) begin
    for (int t = 0; t < NTERM; t++) begin
      if (w_cfg_ok && (i_cfg_idx == IW'(t))) begin
        r_care[t] <= i_cfg_care;
        r_val[t]  <= i_cfg_val;
      end
    end
  end

  assign o_busy        = r_busy;
  assign o_in_ready    = r_in_ready;
  assign o_out_valid   = r_out_valid;
  assign o_out_f       = r_f;
  assign o_out_hit_idx = r_hit_idx;
  assign o_out_hit_cnt = r_hit_cnt;

endmodule

// File: tb/tb_sop_eval_seq.sv
// tb/tb_sop_eval_seq.sv - scoreboard bench for sop_eval_seq against a cube-list reference model
module tb_sop_eval_seq;
  localparam int NIN = 6;
  localparam int NT  = 32;
  localparam int IW  = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic [NIN-1:0] cfg_care = '0, cfg_val = '0;
  logic          cfg_en = 1'b0;
  logic          in_valid = 1'b0;
  logic [NIN-1:0] in_vec = '0;
  logic          out_ready = 1'b0;
  logic          o_busy, o_in_ready, o_out_valid, o_out_f;
  logic [IW-1:0] o_out_hit_idx;
  logic [IW:0]   o_out_hit_cnt;

  sop_eval_seq #(.NIN(NIN), .NTERM(NT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cfg_we(cfg_we), .i_cfg_idx(cfg_idx), .i_cfg_care(cfg_care),
    .i_cfg_val(cfg_val), .i_cfg_en(cfg_en),
    .o_busy(o_busy), .i_in_valid(in_valid), .o_in_ready(o_in_ready),
    .i_in_vec(in_vec), .o_out_valid(o_out_valid), .i_out_ready(out_ready),
    .o_out_f(o_out_f), .o_out_hit_idx(o_out_hit_idx), .o_out_hit_cnt(o_out_hit_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit f;
    int idx;
    int cnt;
    int lat;
    int e0;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   have_cur = 0;
  bit   hold_ready = 0;
  int   checks = 0;
  int   errors = 0;

  logic [NIN-1:0] m_care [NT];
  logic [NIN-1:0] m_val  [NT];
  bit             m_en   [NT];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain list-of-cubes evaluation of the loaded cover
  function automatic exp_t model(input logic [NIN-1:0] x);
    exp_t e;
    int first = -1;
    int n = 0;
    for (int t = 0; t < NT; t++) begin
      if (m_en[t] && (((x ^ m_val[t]) & m_care[t]) == 0)) begin
        n++;
        if (first < 0) first = t;
      end
    end
    e.f   = (n > 0);
    e.idx = e.f ? first : 0;
`ifdef SOP_EVAL_HIT_COUNT_EN
    e.cnt = n;
    e.lat = NT;
`else
    e.cnt = 0;
    e.lat = e.f ? first + 1 : NT;
`endif
    e.e0 = 0;
    return e;
  endfunction

  // Issue one vector, optionally with a same-cycle table write
  task automatic issue(input logic [NIN-1:0] v, input bit wr, input int ci,
                       input logic [NIN-1:0] cc, input logic [NIN-1:0] cv, input bit ce);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!o_in_ready && n < 400) begin @(negedge clk); n++; end
    if (!o_in_ready) begin check("accept_timeout", 0, 1); return; end
    if (wr) begin
      m_care[ci] = cc; m_val[ci] = cv; m_en[ci] = ce;
      cfg_we = 1'b1; cfg_idx = IW'(ci); cfg_care = cc; cfg_val = cv; cfg_en = ce;
    end
    in_valid = 1'b1;
    in_vec   = v;
    e = model(v);
    e.e0 = cyc + 1;
    q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
  endtask

  // Table write alone, issued while idle
  task automatic cfg_write(input int ci, input logic [NIN-1:0] cc, input logic [NIN-1:0] cv, input bit ce);
    int n = 0;
    @(negedge clk);
    while (!o_in_ready && n < 400) begin @(negedge clk); n++; end
    if (!o_in_ready) begin check("cfg_idle_timeout", 0, 1); return; end
    m_care[ci] = cc; m_val[ci] = cv; m_en[ci] = ce;
    cfg_we = 1'b1; cfg_idx = IW'(ci); cfg_care = cc; cfg_val = cv; cfg_en = ce;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || have_cur) && n < 2000) begin @(negedge clk); n++; end
    if (q.size() != 0 || have_cur) check("drain_timeout", 0, 1);
  endtask

  // Consumer ready: random, or held low for backpressure
  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pop on each new result, compare every cycle it is presented
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have_cur = 0;
        continue;
      end
      if (o_out_valid) begin
        if (!have_cur) begin
          if (q.size() == 0) begin
            check("unexpected_out_valid", 1, 0);
          end else begin
            cur = q.pop_front();
            have_cur = 1;
            check("latency", cyc - cur.e0, cur.lat);
          end
        end
        if (have_cur) begin
          check("out_f", int'(o_out_f), int'(cur.f));
          check("out_hit_idx", int'(o_out_hit_idx), cur.idx);
          check("out_hit_cnt", int'(o_out_hit_cnt), cur.cnt);
          check("in_ready_in_done", int'(o_in_ready), 0);
          if (out_ready) have_cur = 0;
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [NIN-1:0] v, cc, cv;
    for (int t = 0; t < NT; t++) begin m_care[t] = '0; m_val[t] = '0; m_en[t] = 0; end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", int'(o_out_valid), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_out_f", int'(o_out_f), 0);
    check("rst_hit_idx", int'(o_out_hit_idx), 0);
    check("rst_hit_cnt", int'(o_out_hit_cnt), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", int'(o_in_ready), 1);

    // Single fully-specified cube in slot 3
    cfg_write(3, 6'h3F, 6'h2A, 1);
    issue(6'h2A, 0, 0, 0, 0, 0);
    issue(6'h2B, 0, 0, 0, 0, 0);
    drain();

    // Cube with don't-cares in slot 0
    cfg_write(0, 6'h05, 6'h04, 1);
    issue(6'h3E, 0, 0, 0, 0, 0);
    issue(6'h3F, 0, 0, 0, 0, 0);
    drain();

    // Backpressure, plus a table write during DONE that must be dropped
    hold_ready = 1;
    issue(6'h2A, 0, 0, 0, 0, 0);
    n = 0;
    while (!o_out_valid && n < 100) begin @(negedge clk); n++; end
    check("bp_valid_seen", int'(o_out_valid), 1);
    cfg_we = 1'b1; cfg_idx = 5'd5; cfg_care = '0; cfg_val = '0; cfg_en = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    repeat (5) @(negedge clk);
    check("bp_still_valid", int'(o_out_valid), 1);
    check("bp_busy", int'(o_busy), 1);
    hold_ready = 0;
    drain();
    issue(6'h00, 0, 0, 0, 0, 0);
    drain();

    // Same-cycle tautology write and accept
    issue(6'h11, 1, 0, 6'h00, 6'h00, 1);
    drain();

    // Reset in the middle of a long scan
    cfg_write(0, 6'h00, 6'h00, 0);
    issue(6'h00, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midscan_rst_out_valid", int'(o_out_valid), 0);
    check("midscan_rst_busy", int'(o_busy), 0);
    q.delete();
    for (int t = 0; t < NT; t++) m_en[t] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(6'h2A, 0, 0, 0, 0, 0);
    drain();

    // 17-cube cover, exhaustive sweep
    for (int t = 0; t < 17; t++) begin
      cc = NIN'($urandom_range(0, 63)) | NIN'(1 << $urandom_range(0, 5));
      cv = NIN'($urandom_range(0, 63));
      cfg_write(t, cc, cv, 1);
    end
    for (int x = 0; x < 64; x++) issue(NIN'(x), 0, 0, 0, 0, 0);
    drain();

    // Random table churn mixed with evaluations
    for (int i = 0; i < 30; i++) begin
      cc = NIN'($urandom_range(0, 63));
      cv = NIN'($urandom_range(0, 63));
      v  = NIN'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 0)
        issue(v, 1, $urandom_range(0, NT - 1), cc, cv, $urandom_range(0, 3) != 0);
      else begin
        cfg_write($urandom_range(0, NT - 1), cc, cv, $urandom_range(0, 3) != 0);
        issue(v, 0, 0, 0, 0, 0);
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
